// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter giving one requester at a time a burst of up to MAXBURST beats on a shared FIFO write port.
// One IDLE arbitration cycle precedes each burst; wfull stalls the burst in place without a timeout.
module fifo_wr_arbiter #(
  parameter int DSIZE    = 8,
  parameter int NREQ     = 4,
  parameter int MAXBURST = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*DSIZE-1:0]     req_data,
  input  logic                      wfull,
  output logic [NREQ-1:0]           ack,
  output logic                      winc,
  output logic [DSIZE-1:0]          wdata,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic                      busy,
  output logic                      burst_end
);

  localparam int OW = $clog2(NREQ);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state, state_nxt;
  logic [OW-1:0]   last_owner, last_owner_nxt, owner_nxt, pick;
  logic [3:0]      beat_cnt, beat_cnt_nxt;
  logic            found;
  logic [DSIZE-1:0] slot [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_slot
    assign slot[i] = req_data[i*DSIZE +: DSIZE];
  end

  // Scan starts just after the previous grant holder so every requester gets a turn.
  always_comb begin : rr_pick
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && req[OW'((int'(last_owner) + k) % NREQ)]) begin
        found = 1'b1;
        pick  = OW'((int'(last_owner) + k) % NREQ);
      end
    end
  end

  // Gating with rst keeps a beat from being written in the cycle reset hits.
  always_comb begin : outputs
    winc      = 1'b0;
    ack       = '0;
    wdata     = '0;
    busy      = 1'b0;
    burst_end = 1'b0;
    if (!rst && state == BURST) begin
      busy      = 1'b1;
      wdata     = slot[owner];
      winc      = req[owner] & ~wfull;
      ack       = winc ? (NREQ'(1) << owner) : '0;
      burst_end = ~req[owner] | (winc & (beat_cnt == 4'(MAXBURST - 1)));
    end
  end

  always_comb begin : next_state
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    beat_cnt_nxt   = beat_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt      = BURST;
          owner_nxt      = pick;
          last_owner_nxt = pick;
          beat_cnt_nxt   = '0;
        end
      end
      BURST: begin
        if (winc)      beat_cnt_nxt = beat_cnt + 4'd1;
        if (burst_end) state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= OW'(NREQ - 1);
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      beat_cnt   <= beat_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed vector table, corner-case sequences and random traffic against a burst-level model.
module tb_fifo_wr_arbiter;
  localparam int DSIZE = 8;
  localparam int NREQ  = 4;
  localparam int MAXB  = 4;
  localparam int OW    = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*DSIZE-1:0] req_data = '0;
  logic                  wfull = 1'b0;
  logic [NREQ-1:0]       ack;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic [OW-1:0]         owner;
  logic                  busy;
  logic                  burst_end;

  fifo_wr_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .MAXBURST(MAXB)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .wfull(wfull),
    .ack(ack), .winc(winc), .wdata(wdata), .owner(owner), .busy(busy), .burst_end(burst_end)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Burst-level model: who holds the grant (-1 = nobody), beats done, rotation pointer.
  int m_cur = -1, m_owner = 0, m_last = NREQ - 1, m_beats = 0;
  logic             e_winc, e_busy, e_be;
  logic [NREQ-1:0]  e_ack;
  logic [DSIZE-1:0] e_wdata;
  logic [OW-1:0]    e_owner;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_predict();
    e_winc = 1'b0; e_ack = '0; e_wdata = '0; e_busy = 1'b0; e_be = 1'b0;
    e_owner = rst ? '0 : OW'(m_owner);
    if (!rst && m_cur >= 0) begin
      e_busy  = 1'b1;
      e_wdata = req_data[m_cur*DSIZE +: DSIZE];
      e_winc  = req[m_cur] && !wfull;
      if (e_winc) e_ack[m_cur] = 1'b1;
      e_be    = !req[m_cur] || (e_winc && (m_beats + 1 == MAXB));
    end
  endtask

  task automatic model_advance();
    bit got;
    got = 1'b0;
    if (rst) begin
      m_cur = -1; m_owner = 0; m_last = NREQ - 1; m_beats = 0;
    end else if (m_cur < 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (!got && req[(m_last + k) % NREQ]) begin
          got = 1'b1;
          m_cur = (m_last + k) % NREQ; m_owner = m_cur; m_last = m_cur; m_beats = 0;
        end
      end
    end else if (e_be) begin
      m_cur = -1;
    end else if (e_winc) begin
      m_beats++;
    end
  endtask

  // One clock: drive after the edge, sample at the falling edge, compare with model.
  task automatic step(input logic [NREQ-1:0] r, input logic wf, input logic rs,
                      input logic [NREQ*DSIZE-1:0] d);
    @(posedge clk); #1;
    req = r; wfull = wf; rst = rs; req_data = d;
    @(negedge clk);
    model_predict();
    chk("m_winc", winc, e_winc);
    chk("m_ack", ack, e_ack);
    chk("m_wdata", wdata, e_wdata);
    chk("m_owner", owner, e_owner);
    chk("m_busy", busy, e_busy);
    chk("m_burst_end", burst_end, e_be);
    model_advance();
  endtask

  typedef struct packed {
    logic       rs;
    logic [3:0] r;
    logic       wf;
    logic       xw;
    logic [3:0] xa;
    logic [1:0] xo;
    logic       xb;
    logic       xe;
    logic [7:0] xd;
  } vec_t;

  localparam logic [31:0] D = 32'h44332211;
  vec_t tbl [13];
  int   n_winc, nb, cnt, rr_exp;
  logic prev_busy;
  logic [3:0] rr;

  initial begin
    tbl[0]  = '{1'b1, 4'b0101, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 4'b0101, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 4'b0101, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 8'h11};
    tbl[3]  = '{1'b0, 4'b0101, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 8'h11};
    tbl[4]  = '{1'b0, 4'b0101, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 8'h11};
    tbl[5]  = '{1'b0, 4'b0101, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 8'h11};
    tbl[6]  = '{1'b0, 4'b0101, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00};
    tbl[7]  = '{1'b0, 4'b0101, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 8'h33};
    tbl[8]  = '{1'b0, 4'b0101, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 8'h33};
    tbl[9]  = '{1'b0, 4'b0101, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 8'h33};
    tbl[10] = '{1'b0, 4'b0101, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 8'h33};
    tbl[11] = '{1'b0, 4'b0101, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0, 8'h00};
    tbl[12] = '{1'b0, 4'b0101, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 8'h11};

    // Two requesters after reset: owner 0 then owner 2, one bubble between.
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].r, tbl[i].wf, tbl[i].rs, D);
      chk("tbl_winc", winc, tbl[i].xw);
      chk("tbl_ack", ack, tbl[i].xa);
      chk("tbl_owner", owner, tbl[i].xo);
      chk("tbl_busy", busy, tbl[i].xb);
      chk("tbl_burst_end", burst_end, tbl[i].xe);
      chk("tbl_wdata", wdata, tbl[i].xd);
    end

    // Requester 1 drops valid after two beats.
    step('0, 1'b0, 1'b1, D);
    step(4'b0010, 1'b0, 1'b0, D);
    n_winc = 0;
    for (int i = 0; i < 2; i++) begin
      step(4'b0010, 1'b0, 1'b0, D);
      n_winc += int'(winc);
    end
    step(4'b0000, 1'b0, 1'b0, D);
    chk("drop_winc", winc, 1'b0);
    chk("drop_burst_end", burst_end, 1'b1);
    chk("drop_beats", n_winc, 2);
    step(4'b0000, 1'b0, 1'b0, D);
    chk("drop_idle", busy, 1'b0);

    // FIFO full for three cycles after beat 2.
    step('0, 1'b0, 1'b1, D);
    step(4'b0001, 1'b0, 1'b0, D);
    n_winc = 0;
    for (int i = 0; i < 2; i++) begin
      step(4'b0001, 1'b0, 1'b0, D);
      n_winc += int'(winc);
    end
    for (int i = 0; i < 3; i++) begin
      step(4'b0001, 1'b1, 1'b0, D);
      chk("stall_winc", winc, 1'b0);
      chk("stall_ack", ack, 4'b0000);
      chk("stall_owner", owner, 2'd0);
      chk("stall_busy", busy, 1'b1);
    end
    for (int i = 0; i < 2; i++) begin
      step(4'b0001, 1'b0, 1'b0, D);
      n_winc += int'(winc);
      chk("stall_end", burst_end, (i == 1));
    end
    chk("stall_beats", n_winc, 4);

    // Reset during beat 3 of owner 2, then owner 2 gets a fresh full burst.
    step('0, 1'b0, 1'b1, D);
    for (int i = 0; i < 3; i++) step(4'b0100, 1'b0, 1'b0, D);
    step(4'b0100, 1'b0, 1'b1, D);
    chk("rst_winc", winc, 1'b0);
    chk("rst_ack", ack, 4'b0000);
    chk("rst_wdata", wdata, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_owner", owner, 2'd0);
    step(4'b0100, 1'b0, 1'b0, D);
    for (int i = 0; i < MAXB; i++) begin
      step(4'b0100, 1'b0, 1'b0, D);
      chk("rst_regrant_owner", owner, 2'd2);
      chk("rst_regrant_winc", winc, 1'b1);
      chk("rst_regrant_end", burst_end, (i == MAXB - 1));
    end

    // All requesting: grants rotate 0,1,2,3,... with full bursts.
    step('0, 1'b0, 1'b1, D);
    prev_busy = 1'b0; nb = 0; cnt = 0; rr_exp = 0;
    for (int i = 0; i < 40; i++) begin
      step(4'b1111, 1'b0, 1'b0, {$urandom});
      if (busy && !prev_busy) begin
        chk("rr_owner", owner, rr_exp);
        rr_exp = (rr_exp + 1) % NREQ;
        nb++;
        cnt = 0;
      end
      cnt += int'(winc);
      if (burst_end) chk("rr_beats", cnt, MAXB);
      prev_busy = busy;
    end
    chk("rr_bursts", nb, 8);

    // Random traffic with occasional full and reset.
    step('0, 1'b0, 1'b1, D);
    rr = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rr = 4'($urandom_range(0, 15));
      step(rr, ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0), {$urandom});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter DSIZE, default 8, meaning data width per requester and per FIFO write beat.
REQ-002 The block SHALL have parameter NREQ, default 4, meaning number of requesters sharing one FIFO write port (2..8).
REQ-003 The block SHALL have parameter MAXBURST, default 4, meaning max beats per grant (1..15).
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, the FIFO write-domain clock; all state on rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous assert, active-high.
REQ-006 The block SHALL have port req, input, NREQ bits: per-requester data-valid, bit i owned by requester i.
REQ-007 The block SHALL have port req_data, input, NREQ*DSIZE bits: requester i data at bits [i*DSIZE +: DSIZE].
REQ-008 The block SHALL have port wfull, input, 1 bit: FIFO full flag, same clock domain.
REQ-009 The block SHALL have port ack, output, NREQ bits: one-hot; ack[i]=1 means requester i's beat is written this cycle.
REQ-010 The block SHALL have port winc, output, 1 bit: FIFO write enable.
REQ-011 The block SHALL have port wdata, output, DSIZE bits: FIFO write data.
REQ-012 The block SHALL have port owner, output, clog2(NREQ) bits: index of the current grant holder.
REQ-013 The block SHALL have port busy, output, 1 bit: high while in BURST.
REQ-014 The block SHALL have port burst_end, output, 1 bit: single-cycle pulse on the cycle a burst terminates.

Function
REQ-015 The FSM SHALL have two states, IDLE and BURST, plus registers owner, last_owner and beat_cnt (4 bits).
REQ-016 In IDLE with req!=0, the FSM SHALL select the first set req bit scanning last_owner+1, last_owner+2, ... modulo NREQ, load owner and last_owner with it, clear beat_cnt, and enter BURST next cycle.
REQ-017 In IDLE with req==0, the FSM SHALL stay in IDLE and SHALL assert no winc or ack.
REQ-018 In BURST, winc SHALL equal req[owner] & ~wfull, combinationally.
REQ-019 ack SHALL equal winc shifted to bit owner; all other ack bits SHALL be 0.
REQ-020 wdata SHALL equal the req_data slice of owner in BURST and SHALL be all zeros in IDLE.
REQ-021 beat_cnt SHALL increment by 1 on each cycle with winc=1.
REQ-022 A burst SHALL end when winc=1 and beat_cnt==MAXBURST-1.
REQ-023 A burst SHALL also end when req[owner]=0 in BURST, whether or not wfull is high.
REQ-024 On burst end the FSM SHALL go to IDLE and SHALL assert burst_end for that cycle.
REQ-025 While wfull=1 and req[owner]=1, the FSM SHALL hold BURST, owner and beat_cnt unchanged, with winc=0 (no timeout).
REQ-026 Arbitration latency SHALL be exactly one IDLE cycle between bursts, so one idle bubble separates back-to-back bursts.
REQ-027 Requests from non-owners arriving during BURST SHALL be ignored until the next IDLE.
REQ-028 Round-robin fairness: with all req bits high, grants SHALL rotate 0,1,...,NREQ-1,0,...

Reset
REQ-029 On rst=1 the block SHALL immediately force state=IDLE, owner=0, last_owner=NREQ-1, beat_cnt=0, busy=0, burst_end=0, winc=0, ack=0 and wdata=0, including mid-burst.
REQ-030 After rst deasserts, the first grant SHALL go to the lowest-index requesting requester.
REQ-031 A beat whose cycle coincides with rst=1 SHALL NOT be written (winc=0).

Verification
REQ-032 Reset release, req=4'b0101, wfull=0, MAXBURST=4, requesters holding valid -> IDLE 1 cycle, owner=0, 4 beats with ack=0001, burst_end, IDLE, owner=2, 4 beats with ack=0100.
REQ-033 Owner 1 holds req for 2 beats then drops it -> winc for 2 cycles, burst_end on the drop cycle, beat_cnt not reaching 4.
REQ-034 wfull=1 for 3 cycles mid-burst after beat 2 -> winc=0 and ack=0 for those 3 cycles, owner unchanged, beats 3-4 complete afterwards, 4 beats total.
REQ-035 req=4'b1111 held 40 cycles -> owner sequence 0,1,2,3,0,... with 4 beats each and one bubble between bursts; wdata matches each owner slice.
REQ-036 rst pulsed during beat 3 of owner 2 -> outputs zero immediately; after release with req=4'b0100, owner=2 granted with beat_cnt=0.
